// File: rtl/tcp_tx_pipe_ctrl.sv
// Control FSM for tcp_tx_datap: sequences one scheduler TX request through
// parallel state reads, a joined response, datapath store strobes and the outputs.
module tcp_tx_pipe_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             sched_tx_req_val,
  output logic             tx_sched_req_rdy,

  output logic             tail_rd_req_val,
  input  logic             tail_rd_req_rdy,
  input  logic             tail_rd_resp_val,
  output logic             tail_rd_resp_rdy,

  output logic             curr_tx_rd_req_val,
  input  logic             curr_tx_rd_req_rdy,
  input  logic             curr_tx_rd_resp_val,
  output logic             curr_tx_rd_resp_rdy,

  output logic             rx_rd_req_val,
  input  logic             rx_rd_req_rdy,
  input  logic             rx_rd_resp_val,
  output logic             rx_rd_resp_rdy,

  output logic             tuple_rd_req_val,
  input  logic             tuple_rd_req_rdy,
  input  logic             tuple_rd_resp_val,
  output logic             tuple_rd_resp_rdy,

  output logic             next_tx_state_wr_req_val,
  input  logic             next_tx_state_wr_req_rdy,
  output logic             tx_sched_update_val,
  input  logic             tx_sched_update_rdy,
  output logic             proto_calc_tx_pkt_val,
  input  logic             proto_calc_tx_pkt_rdy,

  input  logic             datap_ctrl_produce_pkt,

  output logic             ctrl_datap_store_flowid,
  output logic             ctrl_datap_store_state,
  output logic             ctrl_datap_store_tuple,
  output logic             ctrl_datap_store_calc,
  output logic             ctrl_datap_store_sched,

  output logic [CNT_W-1:0] tx_pkt_cnt,
  output logic [CNT_W-1:0] tx_nopkt_cnt
);

  localparam int unsigned NUM_RD  = 4;
  localparam int unsigned NUM_OUT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_CALC,
    ST_SCHED,
    ST_ISSUE
  } state_e;

  state_e               state_q;
  logic [NUM_RD-1:0]    req_done_q, req_done_d;
  logic [NUM_OUT-1:0]   out_done_q, out_done_d;
  logic                 pkt_pend_q;
  logic [CNT_W-1:0]     tx_pkt_cnt_q, tx_nopkt_cnt_q;

  logic [NUM_RD-1:0]    rd_req_val, rd_req_rdy, rd_resp_val;
  logic [NUM_OUT-1:0]   out_val, out_rdy;
  logic                 all_v;
  logic                 in_rd_req, in_rd_resp, in_issue;

  assign in_rd_req  = (state_q == ST_RD_REQ);
  assign in_rd_resp = (state_q == ST_RD_RESP);
  assign in_issue   = (state_q == ST_ISSUE);

  // Channel vectors: bit 0 tail, 1 curr_tx, 2 rx, 3 tuple
  assign rd_req_rdy  = {tuple_rd_req_rdy, rx_rd_req_rdy, curr_tx_rd_req_rdy, tail_rd_req_rdy};
  assign rd_resp_val = {tuple_rd_resp_val, rx_rd_resp_val, curr_tx_rd_resp_val, tail_rd_resp_val};
  assign rd_req_val  = {NUM_RD{in_rd_req}} & ~req_done_q;
  assign all_v       = &rd_resp_val;

  // Output vectors: bit 0 state write, 1 scheduler update, 2 packet
  assign out_rdy = {proto_calc_tx_pkt_rdy, tx_sched_update_rdy, next_tx_state_wr_req_rdy};
  assign out_val = {NUM_OUT{in_issue}} & ~out_done_q;

  assign req_done_d = req_done_q | (rd_req_val & rd_req_rdy);
  assign out_done_d = out_done_q | (out_val & out_rdy);

  assign tail_rd_req_val    = rd_req_val[0];
  assign curr_tx_rd_req_val = rd_req_val[1];
  assign rx_rd_req_val      = rd_req_val[2];
  assign tuple_rd_req_val   = rd_req_val[3];

  // Join: no response is consumed until all four are present
  assign tail_rd_resp_rdy    = in_rd_resp & all_v;
  assign curr_tx_rd_resp_rdy = in_rd_resp & all_v;
  assign rx_rd_resp_rdy      = in_rd_resp & all_v;
  assign tuple_rd_resp_rdy   = in_rd_resp & all_v;

  assign next_tx_state_wr_req_val = out_val[0];
  assign tx_sched_update_val      = out_val[1];
  assign proto_calc_tx_pkt_val    = out_val[2];

  assign tx_sched_req_rdy        = (state_q == ST_IDLE);
  assign ctrl_datap_store_flowid = (state_q == ST_IDLE) & sched_tx_req_val;
  assign ctrl_datap_store_state  = in_rd_resp & all_v;
  assign ctrl_datap_store_tuple  = in_rd_resp & all_v;
  assign ctrl_datap_store_calc   = (state_q == ST_CALC);
  assign ctrl_datap_store_sched  = (state_q == ST_SCHED);

  assign tx_pkt_cnt   = tx_pkt_cnt_q;
  assign tx_nopkt_cnt = tx_nopkt_cnt_q;

  // Sequencer and bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      req_done_q     <= '0;
      out_done_q     <= '0;
      pkt_pend_q     <= 1'b0;
      tx_pkt_cnt_q   <= '0;
      tx_nopkt_cnt_q <= '0;
    end else begin
      if (out_val[2] && out_rdy[2]) begin
        tx_pkt_cnt_q <= tx_pkt_cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (sched_tx_req_val) begin
            req_done_q <= '0;
            state_q    <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          req_done_q <= req_done_d;
          if (&req_done_d) begin
            state_q <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (all_v) begin
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          state_q <= ST_SCHED;
        end
        ST_SCHED: begin
          // A flow with nothing to send has its packet pre-marked as done
          pkt_pend_q <= datap_ctrl_produce_pkt;
          out_done_q <= {~datap_ctrl_produce_pkt, 2'b00};
          state_q    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          out_done_q <= out_done_d;
          if (&out_done_d) begin
            state_q <= ST_IDLE;
            if (!pkt_pend_q) begin
              tx_nopkt_cnt_q <= tx_nopkt_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_pipe_ctrl.sv
// Bench for tcp_tx_pipe_ctrl: drives randomized memory/sink timing and checks every
// cycle against a transaction timeline computed from the request's delay profile.
module tb_tcp_tx_pipe_ctrl;

  localparam int unsigned CNT_W = 32;
  localparam logic [16:0] IDLE_OUTS = 17'h10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             sched_tx_req_val;
  logic [3:0]       rd_req_rdy, rd_resp_val;
  logic             wr_rdy, upd_rdy, pkt_rdy, produce;

  wire              req_rdy;
  wire              tail_rv, curr_rv, rx_rv, tuple_rv;
  wire              tail_pr, curr_pr, rx_pr, tuple_pr;
  wire              wr_val, upd_val, pkt_val;
  wire              s_flow, s_state, s_tuple, s_calc, s_sched;
  wire [CNT_W-1:0]  pkt_cnt, nopkt_cnt;

  tcp_tx_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .sched_tx_req_val         (sched_tx_req_val),
    .tx_sched_req_rdy         (req_rdy),
    .tail_rd_req_val          (tail_rv),
    .tail_rd_req_rdy          (rd_req_rdy[0]),
    .tail_rd_resp_val         (rd_resp_val[0]),
    .tail_rd_resp_rdy         (tail_pr),
    .curr_tx_rd_req_val       (curr_rv),
    .curr_tx_rd_req_rdy       (rd_req_rdy[1]),
    .curr_tx_rd_resp_val      (rd_resp_val[1]),
    .curr_tx_rd_resp_rdy      (curr_pr),
    .rx_rd_req_val            (rx_rv),
    .rx_rd_req_rdy            (rd_req_rdy[2]),
    .rx_rd_resp_val           (rd_resp_val[2]),
    .rx_rd_resp_rdy           (rx_pr),
    .tuple_rd_req_val         (tuple_rv),
    .tuple_rd_req_rdy         (rd_req_rdy[3]),
    .tuple_rd_resp_val        (rd_resp_val[3]),
    .tuple_rd_resp_rdy        (tuple_pr),
    .next_tx_state_wr_req_val (wr_val),
    .next_tx_state_wr_req_rdy (wr_rdy),
    .tx_sched_update_val      (upd_val),
    .tx_sched_update_rdy      (upd_rdy),
    .proto_calc_tx_pkt_val    (pkt_val),
    .proto_calc_tx_pkt_rdy    (pkt_rdy),
    .datap_ctrl_produce_pkt   (produce),
    .ctrl_datap_store_flowid  (s_flow),
    .ctrl_datap_store_state   (s_state),
    .ctrl_datap_store_tuple   (s_tuple),
    .ctrl_datap_store_calc    (s_calc),
    .ctrl_datap_store_sched   (s_sched),
    .tx_pkt_cnt               (pkt_cnt),
    .tx_nopkt_cnt             (nopkt_cnt)
  );

  logic [16:0] outs;
  assign outs = {req_rdy, tuple_rv, rx_rv, curr_rv, tail_rv,
                 tuple_pr, rx_pr, curr_pr, tail_pr,
                 s_flow, s_state, s_tuple, s_calc, s_sched,
                 wr_val, upd_val, pkt_val};

  int n_cmp = 0;
  int n_err = 0;
  int unsigned m_pkt = 0;
  int unsigned m_nopkt = 0;

  // Transaction profile: request-accept delay, response latency, output-accept delay
  int t_a[4];
  int t_r[4];
  int t_o[3];
  bit t_prod;
  int t_gap;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    check_eq({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt));
    check_eq({tag, "_nopkt_cnt"}, 64'(nopkt_cnt), 64'(m_nopkt));
  endtask

  task automatic drive_idle();
    sched_tx_req_val = 1'b0;
    rd_resp_val      = 4'b0;
    rd_req_rdy       = 4'($urandom);
    wr_rdy           = 1'($urandom);
    upd_rdy          = 1'($urandom);
    pkt_rdy          = 1'($urandom);
    produce          = 1'($urandom);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    drive_idle();
    #1;
    check_eq(tag, 64'(outs), 64'(IDLE_OUTS));
    check_cnts(tag);
  endtask

  // Runs one request; abort_cyc >= 0 pulls reset in that cycle instead of finishing
  task automatic run_txn(input string name, input int abort_cyc);
    int acc[4];
    int L, J, I, E;
    logic [3:0] rdv;
    logic [16:0] exp;
    bit wv, uv, pv;
    for (int g = 0; g < t_gap; g++) idle_cycle({name, "_gap"});
    L = 0;
    J = 0;
    for (int x = 0; x < 4; x++) begin
      acc[x] = 1 + t_a[x];
      if (acc[x] > L) L = acc[x];
    end
    J = L + 1;
    for (int x = 0; x < 4; x++) if (acc[x] + t_r[x] > J) J = acc[x] + t_r[x];
    I = J + 3;
    E = I + ((t_o[0] > t_o[1]) ? t_o[0] : t_o[1]);
    if (t_prod && (I + t_o[2] > E)) E = I + t_o[2];
    for (int cyc = 0; cyc <= E; cyc++) begin
      @(negedge clk);
      sched_tx_req_val = (cyc == 0);
      for (int x = 0; x < 4; x++) begin
        rd_req_rdy[x]  = (cyc >= 1 && cyc <= acc[x]) ? (cyc == acc[x]) : 1'($urandom);
        rd_resp_val[x] = (cyc >= acc[x] + t_r[x]) && (cyc <= J);
      end
      wr_rdy  = (cyc >= I && cyc <= I + t_o[0]) ? (cyc == I + t_o[0]) : 1'($urandom);
      upd_rdy = (cyc >= I && cyc <= I + t_o[1]) ? (cyc == I + t_o[1]) : 1'($urandom);
      pkt_rdy = (t_prod && cyc >= I && cyc <= I + t_o[2]) ? (cyc == I + t_o[2]) : 1'($urandom);
      produce = (cyc == J + 2) ? t_prod : 1'($urandom);
      if (cyc == abort_cyc) begin
        rst = 1'b0;
        #1;
        check_eq({name, "_rst_outs"}, 64'(outs), 64'(IDLE_OUTS));
        m_pkt = 0;
        m_nopkt = 0;
        check_cnts({name, "_rst"});
        return;
      end
      #1;
      for (int x = 0; x < 4; x++) rdv[x] = (cyc >= 1 && cyc <= acc[x]);
      wv = (cyc >= I && cyc <= I + t_o[0]);
      uv = (cyc >= I && cyc <= I + t_o[1]);
      pv = t_prod && (cyc >= I && cyc <= I + t_o[2]);
      exp = {cyc == 0, rdv, {4{cyc == J}}, cyc == 0, cyc == J, cyc == J,
             cyc == J + 1, cyc == J + 2, wv, uv, pv};
      check_eq($sformatf("%s_c%0d", name, cyc), 64'(outs), 64'(exp));
      check_cnts($sformatf("%s_c%0d", name, cyc));
      if (t_prod && cyc == I + t_o[2]) m_pkt++;
      if (!t_prod && cyc == E) m_nopkt++;
    end
  endtask

  task automatic set_profile(input int a0, input int a1, input int a2, input int a3,
                             input int r0, input int r1, input int r2, input int r3,
                             input int o0, input int o1, input int o2,
                             input bit prod, input int gap);
    t_a[0] = a0; t_a[1] = a1; t_a[2] = a2; t_a[3] = a3;
    t_r[0] = r0; t_r[1] = r1; t_r[2] = r2; t_r[3] = r3;
    t_o[0] = o0; t_o[1] = o1; t_o[2] = o2;
    t_prod = prod;
    t_gap  = gap;
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    #1;
    check_eq("reset_outs", 64'(outs), 64'(IDLE_OUTS));
    check_cnts("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_cycle("post_reset");

    // Back-to-back flows 3 and 7, everything ready, 1-cycle responses
    set_profile(0,0,0,0, 1,1,1,1, 0,0,0, 1'b1, 0);
    run_txn("flow3", -1);
    run_txn("flow7", -1);
    idle_cycle("b2b_done");
    check_eq("b2b_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Tuple request held off for 4 cycles
    set_profile(0,0,0,4, 1,1,1,1, 0,0,0, 1'b1, 1);
    run_txn("tuple_stall", -1);

    // Staggered responses: tail +1, curr_tx +2, rx +3, tuple +5
    set_profile(0,0,0,0, 1,2,3,5, 0,0,0, 1'b1, 0);
    run_txn("stagger", -1);

    // No packet required
    set_profile(0,0,0,0, 1,1,1,1, 0,0,0, 1'b0, 2);
    run_txn("nopkt", -1);
    idle_cycle("nopkt_done");
    check_eq("nopkt_cnt_one", 64'(nopkt_cnt), 64'd1);

    // Update held off 3 cycles while write and packet go at once
    set_profile(0,0,0,0, 1,1,1,1, 0,3,0, 1'b1, 0);
    run_txn("upd_stall", -1);

    // Reset while waiting on responses
    set_profile(0,0,0,0, 5,5,5,5, 0,0,0, 1'b1, 0);
    run_txn("rst_mid", 3);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    check_eq("rst_release", 64'(outs), 64'(IDLE_OUTS));
    set_profile(0,1,0,0, 1,1,2,1, 1,0,0, 1'b1, 0);
    run_txn("after_rst", -1);

    for (int n = 0; n < 40; n++) begin
      set_profile($urandom_range(0,4), $urandom_range(0,4), $urandom_range(0,4), $urandom_range(0,4),
                  $urandom_range(1,5), $urandom_range(1,5), $urandom_range(1,5), $urandom_range(1,5),
                  $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
                  1'($urandom), $urandom_range(0,2));
      run_txn($sformatf("rnd%0d", n), -1);
    end
    idle_cycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
